// File: rtl/fp_addsub_seq_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// fp_addsub_seq_ctrl_pkg
// Shared definitions for the FP add/sub sequencer: FSM state encodings,
// operation codes, default normalisation limits and the result-sign
// resolution helper used when the ROUND step commits the sign register.
// No ports; imported by fp_addsub_seq_ctrl and fp_addsub_seq_ctrl_rr_arb2.
// ---------------------------------------------------------------------------
package fp_addsub_seq_ctrl_pkg;

   // Single-precision mantissa width bounds the number of normalisation
   // steps; the counter width must be able to hold NORM_MAX - 1.
   localparam int NORM_MAX_DEF = 24;
   localparam int CW_DEF       = 5;

   // Requested operation, before operand signs are folded in.
   typedef enum logic {
      OP_ADD = 1'b0,
      OP_SUB = 1'b1
   } op_t;

   // Sequencer states, one per datapath phase. Encodings are fixed so that
   // state values seen in debug dumps match the datapath documentation.
   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LOAD  = 3'd1,
      ST_ALIGN = 3'd2,
      ST_ADD   = 3'd3,
      ST_NORM  = 3'd4,
      ST_ROUND = 3'd5,
      ST_DONE  = 3'd6
   } state_t;

   // Result sign for a completed (non-exceptional) operation.
   // An effective add always keeps the sign of X. For an effective subtract
   // an exact zero is positive (round-to-nearest-even rule), otherwise the
   // larger magnitude decides: the exponent compare when exponents differ,
   // the mantissa difference sign when they are equal.
   function automatic logic resolve_sign(input logic eop,
                                         input logic res_zero,
                                         input logic zero_d,
                                         input logic cmp,
                                         input logic sign_d,
                                         input logic sx);
      logic sz;
      if (!eop) begin
         sz = sx;
      end else if (res_zero) begin
         sz = 1'b0;
      end else if (!zero_d) begin
         sz = cmp ? ~sx : sx;
      end else begin
         sz = sign_d ? ~sx : sx;
      end
      return sz;
   endfunction

endpackage

// File: rtl/fp_addsub_seq_ctrl_rr_arb2.sv
// ---------------------------------------------------------------------------
// fp_addsub_seq_ctrl_rr_arb2
// Two-input round-robin arbiter. The grant is combinational from the
// request vector and a priority pointer; the pointer only moves when the
// grant is actually taken (adv), so a requester that is passed over keeps
// its turn until the sequencer is free to accept it.
// Ports:
//   clk    in   system clock, rising edge
//   rst_n  in   asynchronous active-low reset (pointer -> requester 0)
//   req    in   [1:0] request vector
//   adv    in   grant consumed this cycle
//   gnt    out  [1:0] one-hot grant (zero when no request)
// ---------------------------------------------------------------------------
module fp_addsub_seq_ctrl_rr_arb2
   import fp_addsub_seq_ctrl_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] req,
   input  logic       adv,
   output logic [1:0] gnt
);

   logic ptr;

   // Grant selection: a lone requester always wins; on contention the
   // pointer names the requester that currently holds priority.
   always_comb begin
      gnt = 2'b00;
      case (req)
         2'b01:   gnt = 2'b01;
         2'b10:   gnt = 2'b10;
         2'b11:   gnt = ptr ? 2'b10 : 2'b01;
         default: gnt = 2'b00;
      endcase
   end

   // Priority pointer: after a grant is taken, priority passes to the
   // requester that was not served, so the last winner yields next time.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr <= 1'b0;
      end else if (adv && (|gnt)) begin
         ptr <= gnt[0];
      end
   end

endmodule

// File: rtl/fp_addsub_seq_ctrl.sv
// ---------------------------------------------------------------------------
// fp_addsub_seq_ctrl
// Multi-cycle sequencer and 2-way arbiter for the shared FP add/sub
// datapath. Accepts one request at a time, steps the datapath through
// LOAD/ALIGN/ADD/NORM/ROUND with one-hot registered enables, samples the
// datapath comparison flags, resolves the result sign and presents a tagged
// response that is held until the consumer accepts it.
// Ports:
//   clk, rst_n                 clock / asynchronous active-low reset
//   req_valid/op/sx/sy [1:0]   per-requester request, op and operand signs
//   req_ready [1:0]            one-cycle accept pulse to the granted requester
//   grant_id                   operand-mux select, valid LOAD..DONE
//   dp_ld_ops .. dp_rnd_en     one-hot datapath phase enables
//   dp_eop                     effective subtract, valid ALIGN..ROUND
//   dp_cmp/zero_d/exc          exponent compare flags, sampled in ALIGN
//   dp_sign_d/res_zero         mantissa result flags, sampled in ADD
//   dp_norm_done               normalisation finished, sampled in NORM
//   rsp_valid/ready/id/sz/exc  tagged response handshake
//   busy                       sequencer not idle
// ---------------------------------------------------------------------------
module fp_addsub_seq_ctrl
   import fp_addsub_seq_ctrl_pkg::*;
#(
   parameter int NORM_MAX = NORM_MAX_DEF,
   parameter int CW       = CW_DEF
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] req_valid,
   input  logic [1:0] req_op,
   input  logic [1:0] req_sx,
   input  logic [1:0] req_sy,
   output logic [1:0] req_ready,
   output logic       grant_id,
   output logic       dp_ld_ops,
   output logic       dp_align_en,
   output logic       dp_add_en,
   output logic       dp_eop,
   output logic       dp_norm_en,
   output logic       dp_rnd_en,
   input  logic       dp_cmp,
   input  logic       dp_zero_d,
   input  logic       dp_exc,
   input  logic       dp_sign_d,
   input  logic       dp_res_zero,
   input  logic       dp_norm_done,
   output logic       rsp_valid,
   input  logic       rsp_ready,
   output logic       rsp_id,
   output logic       rsp_sz,
   output logic       rsp_exc,
   output logic       busy
);

   state_t        state;
   logic [1:0]    gnt;
   logic          gnt_idx;
   logic          accept;
   op_t           op_q;
   logic          sx_q;
   logic          sy_q;
   logic          cmp_q;
   logic          zero_d_q;
   logic          sign_d_q;
   logic          res_zero_q;
   logic [CW-1:0] norm_cnt;
   logic          norm_last;

   // A grant is only taken while idle; requests arriving during an
   // operation simply wait at the arbiter input.
   assign accept  = (state == ST_IDLE) && (|req_valid);
   assign gnt_idx = gnt[1];

   // The accept pulse must appear in the same cycle as the arbitration
   // decision, so it is decoded from the state register and the arbiter.
   // It is gated by reset so that no accept is signalled while held in reset.
   assign req_ready = (rst_n && (state == ST_IDLE)) ? gnt : 2'b00;

   assign busy      = (state != ST_IDLE);
   assign norm_last = (norm_cnt == CW'(NORM_MAX - 1));

   fp_addsub_seq_ctrl_rr_arb2 u_arb (
      .clk   (clk),
      .rst_n (rst_n),
      .req   (req_valid),
      .adv   (accept),
      .gnt   (gnt)
   );

   // Main sequencer. Every datapath enable is registered and set on the
   // transition into its phase, so exactly one enable is high for exactly
   // the cycles the FSM spends in that phase. Flag registers capture the
   // datapath status in the phase where it is meaningful, and the response
   // fields are committed before DONE so they are stable while rsp_valid
   // waits for the consumer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= ST_IDLE;
         grant_id    <= 1'b0;
         dp_ld_ops   <= 1'b0;
         dp_align_en <= 1'b0;
         dp_add_en   <= 1'b0;
         dp_eop      <= 1'b0;
         dp_norm_en  <= 1'b0;
         dp_rnd_en   <= 1'b0;
         rsp_valid   <= 1'b0;
         rsp_id      <= 1'b0;
         rsp_sz      <= 1'b0;
         rsp_exc     <= 1'b0;
         op_q        <= OP_ADD;
         sx_q        <= 1'b0;
         sy_q        <= 1'b0;
         cmp_q       <= 1'b0;
         zero_d_q    <= 1'b0;
         sign_d_q    <= 1'b0;
         res_zero_q  <= 1'b0;
         norm_cnt    <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  op_q        <= op_t'(req_op[gnt_idx]);
                  sx_q        <= req_sx[gnt_idx];
                  sy_q        <= req_sy[gnt_idx];
                  grant_id    <= gnt_idx;
                  rsp_id      <= gnt_idx;
                  rsp_sz      <= 1'b0;
                  rsp_exc     <= 1'b0;
                  dp_ld_ops   <= 1'b1;
                  state       <= ST_LOAD;
               end
            end

            ST_LOAD: begin
               dp_ld_ops   <= 1'b0;
               dp_align_en <= 1'b1;
               dp_eop      <= sx_q ^ sy_q ^ (op_q == OP_SUB);
               state       <= ST_ALIGN;
            end

            ST_ALIGN: begin
               dp_align_en <= 1'b0;
               cmp_q       <= dp_cmp;
               zero_d_q    <= dp_zero_d;
               if (dp_exc) begin
                  dp_eop    <= 1'b0;
                  rsp_exc   <= 1'b1;
                  rsp_sz    <= sx_q;
                  rsp_valid <= 1'b1;
                  state     <= ST_DONE;
               end else begin
                  dp_add_en <= 1'b1;
                  state     <= ST_ADD;
               end
            end

            ST_ADD: begin
               dp_add_en  <= 1'b0;
               sign_d_q   <= dp_sign_d;
               res_zero_q <= dp_res_zero;
               norm_cnt   <= '0;
               dp_norm_en <= 1'b1;
               state      <= ST_NORM;
            end

            ST_NORM: begin
               if (dp_norm_done || norm_last) begin
                  dp_norm_en <= 1'b0;
                  dp_rnd_en  <= 1'b1;
                  rsp_exc    <= !dp_norm_done;
                  state      <= ST_ROUND;
               end else begin
                  norm_cnt <= norm_cnt + 1'b1;
               end
            end

            ST_ROUND: begin
               dp_rnd_en <= 1'b0;
               dp_eop    <= 1'b0;
               rsp_sz    <= resolve_sign(dp_eop, res_zero_q, zero_d_q,
                                         cmp_q, sign_d_q, sx_q);
               rsp_valid <= 1'b1;
               state     <= ST_DONE;
            end

            ST_DONE: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  state     <= ST_IDLE;
               end
            end

            default: begin
               dp_ld_ops   <= 1'b0;
               dp_align_en <= 1'b0;
               dp_add_en   <= 1'b0;
               dp_eop      <= 1'b0;
               dp_norm_en  <= 1'b0;
               dp_rnd_en   <= 1'b0;
               rsp_valid   <= 1'b0;
               state       <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
